prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//   Byte-stream program loader: the writer side of the CPU's 16x8 program RAM.
//   Takes a framed image (length, payload, checksum) over a valid/ready stream
//   and writes it into RAM at addresses 0..N-1. Holds the CPU in reset until a
//   good image is loaded, then releases it.
// PARAMETERS
//   ADDR_W  4   RAM address width
//   DATA_W  8   RAM word / stream byte width
//   DEPTH   16  max payload bytes (2**ADDR_W)
// PORTS
//   clk        in   1       clock; all logic on posedge
//   reset      in   1       synchronous, active-high
//   start      in   1       one-cycle pulse; begins a load frame
//   s_valid    in   1       stream byte valid
//   s_ready    out  1       loader can accept a byte
//   s_data     in   DATA_W  stream byte
//   mem_we     out  1       RAM write strobe, one cycle per payload byte
//   mem_addr   out  ADDR_W  RAM write address
//   mem_wdata  out  DATA_W  RAM write data
//   cpu_hold   out  1       1 = keep CPU in reset
//   busy       out  1       frame in progress
//   done       out  1       sticky: last frame good
//   error      out  1       sticky: last frame bad
//   checksum   out  DATA_W  running mod-256 sum of payload bytes
// BEHAVIOUR
//   - Reset values: s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1,
//     busy=0, done=0, error=0, checksum=0, state=IDLE, count=0.
//   - Beat = s_valid & s_ready. s_ready is 1 only in HDR, LOAD and CHK.
//   - IDLE: start -> HDR; busy=1, cpu_hold=1, done/error/checksum cleared.
//   - HDR: beat latches N = s_data. N==0 or N>DEPTH -> ERR; otherwise LOAD
//     with count=0.
//   - LOAD: each beat registers mem_addr=count, mem_wdata=s_data and asserts
//     mem_we the NEXT cycle (latency 1). checksum += s_data. count++; after
//     the Nth beat -> CHK. count never wraps; max address DEPTH-1.
//   - CHK: beat; (checksum + s_data) mod 256 == 0 -> DONE, else -> ERR.
//   - DONE: done=1, busy=0, cpu_hold=0. ERR: error=1, busy=0, cpu_hold=1.
//   - start in DONE or ERR -> HDR, as from IDLE (cpu_hold reasserts the same
//     cycle). start while busy is ignored.
//   - start and s_valid in the same cycle in IDLE: byte not accepted
//     (s_ready=0).
//   - s_valid gaps or stalls in any state: wait, no timeout.
//   - Reset mid-frame -> IDLE with reset values. RAM contents are not
//     cleared. A pending mem_we is dropped.
// CONFIGURATION
//   LOADER_OPCHECK_EN defined:
//     - LOAD checks s_data[7:4] against the legal set {0000, LDA 1000,
//       LDB 0100, ADD 0010, SUB 0001, MUL 1100, DIV 1010, JMP 1001,
//       HLT 1111}.
//     - An illegal nibble -> ERR on that beat. That byte is not written and
//       checksum is not updated.
//   LOADER_OPCHECK_EN undefined: every payload byte is written unchecked.
// STRUCTURE
//   - Shared package cpuf_pkg:
//     - OP_* 4-bit opcode constants;
//     - loader state encoding (IDLE, HDR, LOAD, CHK, DONE, ERR);
//     - function op_legal(nibble).
//   - No sub-module: one FSM plus counter and accumulator in this file.
// TESTING
//   1 Demo image: start, then 06,00,41,FF,02,01,89,34 -> mem_we x6 at addr
//     0..5 with those bytes; checksum=CC; done=1; cpu_hold=0.
//   2 Header 00 -> error=1 after the HDR beat; no mem_we; cpu_hold=1.
//     Header 11 -> same.
//   3 Header 10, 16 bytes of 01, checksum F0 -> addr 0..15 written; done=1;
//     no address wrap.
//   4 Image from test 1 with checksum 35 -> error=1, cpu_hold stays 1; then
//     start and a correct frame -> done=1, error=0.
//   5 s_valid toggled every other cycle, start pulsed mid-LOAD -> only
//     accepted beats written, in order; start ignored.
//   6 Reset after 3 payload beats -> IDLE, busy=0, cpu_hold=1.
//     Payload byte 30: LOADER_OPCHECK_EN defined -> error, not written;
//     undefined -> written.

Source files
------------

// File: rtl/cpuf_pkg.sv
// Shared CPU/loader definitions: opcode constants, loader state encoding and
// the opcode legality helper used by the LOADER_OPCHECK_EN build of prog_loader.
package cpuf_pkg;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_LDA = 4'b1000;
    localparam logic [3:0] OP_LDB = 4'b0100;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b1100;
    localparam logic [3:0] OP_DIV = 4'b1010;
    localparam logic [3:0] OP_JMP = 4'b1001;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR  = 3'd1;
    localparam logic [2:0] ST_LOAD = 3'd2;
    localparam logic [2:0] ST_CHK  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;
    localparam logic [2:0] ST_ERR  = 3'd5;

    function automatic logic op_legal(input logic [3:0] nibble);
        case (nibble)
            OP_NOP, OP_LDA, OP_LDB, OP_ADD, OP_SUB,
            OP_MUL, OP_DIV, OP_JMP, OP_HLT: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/prog_loader.sv
// Byte-stream program loader: writes a framed image (length, payload, checksum)
// into program RAM and holds the CPU until it loads. LOADER_OPCHECK_EN enables opcode checking.
module prog_loader
    import cpuf_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [DATA_W-1:0] checksum
);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [DATA_W-1:0] cks_q, cks_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              beat;
    logic              op_ok;
    logic [DATA_W-1:0] cks_sum;

    assign s_ready  = (state_q == ST_HDR) || (state_q == ST_LOAD) || (state_q == ST_CHK);
    assign busy     = s_ready;
    assign cpu_hold = (state_q != ST_DONE);
    assign beat     = s_valid & s_ready;
    assign cks_sum  = cks_q + s_data;

`ifdef LOADER_OPCHECK_EN
    assign op_ok = op_legal(s_data[DATA_W-1 -: 4]);
`else
    assign op_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        len_d   = len_q;
        cks_d   = cks_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        error_d = error_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_HDR;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    cks_d   = '0;
                end
            end
            ST_HDR: begin
                if (beat) begin
                    len_d   = s_data[ADDR_W:0];
                    count_d = '0;
                    if (s_data == '0 || s_data > DATA_W'(DEPTH)) begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (beat) begin
                    if (!op_ok) begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                    end else begin
                        // Write is registered: mem_we appears the cycle after the beat.
                        we_d    = 1'b1;
                        addr_d  = count_q[ADDR_W-1:0];
                        wdata_d = s_data;
                        cks_d   = cks_sum;
                        count_d = count_q + 1'b1;
                        if ((count_q + 1'b1) == len_q) state_d = ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                if (beat) begin
                    if (cks_sum == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            len_q   <= '0;
            cks_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            len_q   <= len_d;
            cks_q   <= cks_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign done      = done_q;
    assign error     = error_q;
    assign checksum  = cks_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table of frames plus hand-written reset
// and start/valid collision sequences; RAM writes checked through a scoreboard.
module tb_prog_loader;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
`ifdef LOADER_OPCHECK_EN
    localparam bit OPCHK = 1'b1;
`else
    localparam bit OPCHK = 1'b0;
`endif

    typedef struct {
        logic [159:0] bits;
        int           n;
        bit           gap;
        int           start_at;
        logic         exp_done;
        logic         exp_err;
        logic [7:0]   exp_cks;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset, start, s_valid;
    logic              s_ready, mem_we, cpu_hold, busy, done, error;
    logic [DATA_W-1:0] s_data, mem_wdata, checksum;
    logic [ADDR_W-1:0] mem_addr;

    int         checks = 0;
    int         errors = 0;
    logic [11:0] sb[$];
    logic [11:0] exp_w;
    vec_t        vecs[8];

    always #5 clk = ~clk;

    prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .s_valid(s_valid),
        .s_ready(s_ready), .s_data(s_data), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
        .busy(busy), .done(done), .error(error), .checksum(checksum)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit legal(input logic [3:0] nib);
        return nib inside {4'h0, 4'h8, 4'h4, 4'h2, 4'h1, 4'hC, 4'hA, 4'h9, 4'hF};
    endfunction

    function automatic vec_t mk(input logic [159:0] bits, input int n, input bit gap,
                                input int start_at, input logic d, input logic e,
                                input logic [7:0] cks);
        vec_t v;
        v.bits = bits; v.n = n; v.gap = gap; v.start_at = start_at;
        v.exp_done = d; v.exp_err = e; v.exp_cks = cks;
        return v;
    endfunction

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
            end else begin
                exp_w = sb.pop_front();
                chk("mem_write", {20'b0, mem_addr, mem_wdata}, {20'b0, exp_w});
            end
        end
    end

    // Entered and left at a negedge.
    task automatic send_byte(input logic [7:0] d, input bit push, input logic [3:0] a,
                             input bit gap, input bit pulse_start);
        int t = 0;
        s_valid = 1'b1;
        s_data  = d;
        while (s_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (s_ready !== 1'b1) begin
            chk("ready_timeout", {31'b0, s_ready}, 32'd1);
            s_valid = 1'b0;
            return;
        end
        if (push) sb.push_back({a, d});
        @(negedge clk);
        s_valid = 1'b0;
        if (gap) begin
            start = pulse_start;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", {31'b0, busy}, 32'd1);
        chk("start_hold", {31'b0, cpu_hold}, 32'd1);
        chk("start_done_clr", {31'b0, done}, 32'd0);
        chk("start_err_clr", {31'b0, error}, 32'd0);
        chk("start_cks_clr", {24'b0, checksum}, 32'd0);
    endtask

    task automatic end_checks(input string tag, input logic d, input logic e, input logic [7:0] cks);
        repeat (2) @(negedge clk);
        chk({tag, "_done"}, {31'b0, done}, {31'b0, d});
        chk({tag, "_error"}, {31'b0, error}, {31'b0, e});
        chk({tag, "_cks"}, {24'b0, checksum}, {24'b0, cks});
        chk({tag, "_hold"}, {31'b0, cpu_hold}, {31'b0, ~d});
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_sb_empty"}, sb.size(), 32'd0);
    endtask

    task automatic run_frame(input vec_t v, input int idx);
        logic [7:0] hdr, d;
        bit hdr_ok, push;
        pulse_start();
        hdr = v.bits[(v.n-1)*8 +: 8];
        hdr_ok = (hdr != 8'h00) && (hdr <= 8'(DEPTH));
        for (int i = 0; i < v.n; i++) begin
            d = v.bits[(v.n-1-i)*8 +: 8];
            push = (i >= 1) && hdr_ok && (i <= int'(hdr)) && !(OPCHK && !legal(d[7:4]));
            send_byte(d, push, 4'(i-1), v.gap, i == v.start_at);
        end
        end_checks($sformatf("frame%0d", idx), v.exp_done, v.exp_err, v.exp_cks);
    endtask

    initial begin
        vecs[0] = mk({8'h06, 8'h00, 8'h41, 8'hFF, 8'h02, 8'h01, 8'h89, 8'h34}, 8, 1'b0, -1, 1'b1, 1'b0, 8'hCC);
        vecs[1] = mk({8'h00}, 1, 1'b0, -1, 1'b0, 1'b1, 8'h00);
        vecs[2] = mk({8'h11}, 1, 1'b0, -1, 1'b0, 1'b1, 8'h00);
        vecs[3] = mk({8'h10, {16{8'h01}}, 8'hF0}, 18, 1'b0, -1, 1'b1, 1'b0, 8'h10);
        vecs[4] = mk({8'h06, 8'h00, 8'h41, 8'hFF, 8'h02, 8'h01, 8'h89, 8'h35}, 8, 1'b0, -1, 1'b0, 1'b1, 8'hCC);
        vecs[5] = mk({8'h06, 8'h00, 8'h41, 8'hFF, 8'h02, 8'h01, 8'h89, 8'h34}, 8, 1'b0, -1, 1'b1, 1'b0, 8'hCC);
        vecs[6] = mk({8'h06, 8'h00, 8'h41, 8'hFF, 8'h02, 8'h01, 8'h89, 8'h34}, 8, 1'b1, 3, 1'b1, 1'b0, 8'hCC);
`ifdef LOADER_OPCHECK_EN
        vecs[7] = mk({8'h01, 8'h30}, 2, 1'b0, -1, 1'b0, 1'b1, 8'h00);
`else
        vecs[7] = mk({8'h01, 8'h30, 8'hD0}, 3, 1'b0, -1, 1'b1, 1'b0, 8'h30);
`endif

        reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, s_ready}, 32'd0);
        chk("rst_we", {31'b0, mem_we}, 32'd0);
        chk("rst_addr", {28'b0, mem_addr}, 32'd0);
        chk("rst_wdata", {24'b0, mem_wdata}, 32'd0);
        chk("rst_hold", {31'b0, cpu_hold}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_error", {31'b0, error}, 32'd0);
        chk("rst_cks", {24'b0, checksum}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 8; k++) run_frame(vecs[k], k);

        // Reset after three payload beats, with a fourth beat colliding with reset.
        pulse_start();
        send_byte(8'h06, 1'b0, 4'h0, 1'b0, 1'b0);
        send_byte(8'h81, 1'b1, 4'h0, 1'b0, 1'b0);
        send_byte(8'h42, 1'b1, 4'h1, 1'b0, 1'b0);
        send_byte(8'hC3, 1'b1, 4'h2, 1'b0, 1'b0);
        s_valid = 1'b1; s_data = 8'h14; reset = 1'b1;
        @(negedge clk);
        s_valid = 1'b0; reset = 1'b0;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_hold", {31'b0, cpu_hold}, 32'd1);
        chk("midrst_ready", {31'b0, s_ready}, 32'd0);
        chk("midrst_we", {31'b0, mem_we}, 32'd0);
        chk("midrst_addr", {28'b0, mem_addr}, 32'd0);
        chk("midrst_cks", {24'b0, checksum}, 32'd0);
        @(negedge clk);
        chk("midrst_we_dropped", {31'b0, mem_we}, 32'd0);

        // start and s_valid together in IDLE: that byte must not be taken as header.
        start = 1'b1; s_valid = 1'b1; s_data = 8'h02;
        @(negedge clk);
        start = 1'b0; s_valid = 1'b0;
        chk("collide_busy", {31'b0, busy}, 32'd1);
        send_byte(8'h01, 1'b0, 4'h0, 1'b0, 1'b0);
        send_byte(8'h81, 1'b1, 4'h0, 1'b0, 1'b0);
        send_byte(8'h7F, 1'b0, 4'h0, 1'b0, 1'b0);
        end_checks("collide", 1'b1, 1'b0, 8'h81);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
